keypad_scan: RTL and testbench

Scans the 4×4 matrix keypad and delivers debounced presses as the 16-bit one-hot `numbers` bus consumed by the charge-entry and mode-control stages. Bit encoding: bits 0–9 = digits 0–9, 10 = A, 11 = B, 12 = C, 13 = D, 14 = \*, 15 = #. The bus holds the key code while the key is held and returns to all-zero on release, so downstream stages re-arm between presses.

---
 rtl/keypad_scan.sv | 183 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with ghost rejection and scan-level debounce.
// Define KEYPAD_STROBE_EN to drive key_strobe; otherwise it is tied low.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clkin,
  input  logic        rst,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [15:0] numbers,
  output logic [3:0]  key_code,
  output logic        key_strobe
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [3:0]    col_m_q, col_s_q;
  logic [15:0]   acc_q, acc_d;
  logic [4:0]    prev_q, prev_d;
  logic [3:0]    stab_q, stab_d;
  logic [15:0]   numbers_q, numbers_d;
  logic [3:0]    code_q, code_d;

  logic        slot_last, eos;
  logic [15:0] hit;
  logic [4:0]  n_hit;
  logic [3:0]  hit_idx;
  logic [4:0]  res, cmt;

  // intersection index is row*4+col
  function automatic logic [3:0] keymap(input logic [3:0] idx);
    logic [3:0] k;
    k = 4'd0;
    unique case (idx)
      4'd0:  k = 4'd1;
      4'd1:  k = 4'd2;
      4'd2:  k = 4'd3;
      4'd3:  k = 4'd10;
      4'd4:  k = 4'd4;
      4'd5:  k = 4'd5;
      4'd6:  k = 4'd6;
      4'd7:  k = 4'd11;
      4'd8:  k = 4'd7;
      4'd9:  k = 4'd8;
      4'd10: k = 4'd9;
      4'd11: k = 4'd12;
      4'd12: k = 4'd14;
      4'd13: k = 4'd0;
      4'd14: k = 4'd15;
      4'd15: k = 4'd13;
      default: k = 4'd0;
    endcase
    return k;
  endfunction

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q   <= ROW0;
      slot_q    <= '0;
      col_m_q   <= 4'hF;
      col_s_q   <= 4'hF;
      acc_q     <= '0;
      prev_q    <= '0;
      stab_q    <= '0;
      numbers_q <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      col_m_q   <= col;
      col_s_q   <= col_m_q;
      acc_q     <= acc_d;
      prev_q    <= prev_d;
      stab_q    <= stab_d;
      numbers_q <= numbers_d;
      code_q    <= code_d;
    end
  end

  assign slot_last = (slot_q == SLOT_LAST);
  assign eos       = slot_last && (state_q == ROW3);

  always_comb begin
    state_d = state_q;
    if (slot_last) begin
      unique case (state_q)
        ROW0:    state_d = ROW1;
        ROW1:    state_d = ROW2;
        ROW2:    state_d = ROW3;
        ROW3:    state_d = ROW0;
        default: state_d = ROW0;
      endcase
    end
  end

  always_comb begin
    row = 4'b1110;
    unique case (state_q)
      ROW0:    row = 4'b1110;
      ROW1:    row = 4'b1101;
      ROW2:    row = 4'b1011;
      ROW3:    row = 4'b0111;
      default: row = 4'b1110;
    endcase
  end

  always_comb begin
    hit = acc_q;
    if (slot_last)
      hit[{state_q, 2'b00} +: 4] = acc_q[{state_q, 2'b00} +: 4] | ~col_s_q;
  end

  always_comb begin
    n_hit   = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) begin
        n_hit   = n_hit + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  // two or more intersections low is a ghost pattern: treat as no key
  assign res = (n_hit == 5'd1) ? {1'b1, keymap(hit_idx)} : 5'd0;
  assign cmt = {|numbers_q, code_q};

  always_comb begin
    slot_d    = slot_last ? '0 : slot_q + 1'b1;
    acc_d     = eos ? '0 : hit;
    prev_d    = prev_q;
    stab_d    = stab_q;
    numbers_d = numbers_q;
    code_d    = code_q;
    if (eos) begin
      prev_d = res;
      if (res == prev_q)
        stab_d = (stab_q >= DEB) ? DEB : stab_q + 4'd1;
      else
        stab_d = 4'd1;
      if (stab_d == DEB && res != cmt) begin
        if (cmt[4]) begin
          numbers_d = '0;
          code_d    = '0;
        end else begin
          numbers_d = 16'd1 << res[3:0];
          code_d    = res[3:0];
        end
      end
    end
  end

  assign numbers  = numbers_q;
  assign key_code = code_q;

`ifdef KEYPAD_STROBE_EN
  logic strobe_q, strobe_d;

  assign strobe_d = eos && (stab_d == DEB) && !cmt[4] && res[4];

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) strobe_q <= 1'b0;
    else      strobe_q <= strobe_d;
  end

  assign key_strobe = strobe_q;
`else
  assign key_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=2).
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] numbers;
  logic [3:0]  key_code;
  logic        key_strobe;

  logic [15:0] pressed;
  logic [3:0]  glitch;
  logic [3:0]  kp;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  code;
    logic [31:0] gap;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_strobe = 0;
  int unsigned ncyc;

  always #5 clk = ~clk;

  // keypad matrix model: a pressed key shorts its column to the driven row
  always_comb begin
    kp = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r]) kp = kp & ~pressed[r*4 +: 4];
    col = kp ^ glitch;
  end

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clkin      (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .numbers    (numbers),
    .key_code   (key_code),
    .key_strobe (key_strobe)
  );

  always @(posedge clk or negedge rst)
    if (!rst) ncyc <= 0;
    else      ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [15:0] n, input logic [3:0] c,
                      input logic [31:0] g);
    exp_t e;
    e.num  = n;
    e.code = c;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic wait_scans(input int k);
    repeat (k * 16) @(posedge clk);
    @(negedge clk);
  endtask

  // monitor: every change of numbers consumes one scoreboard entry
  initial begin : monitor
    logic [15:0] last_num;
    int unsigned last_chg;
    exp_t        e;
    last_num = '0;
    last_chg = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_num = '0;
        last_chg = 0;
      end else begin
        if (key_strobe) n_strobe++;
        if (numbers !== last_num) begin
          if (sb.size() == 0) begin
            check("unexpected_change", 32'(numbers), 32'(last_num));
          end else begin
            e = sb.pop_front();
            check("numbers", 32'(numbers), 32'(e.num));
            check("key_code", 32'(key_code), 32'(e.code));
            check("commit_phase", ncyc % 16, 0);
            if (e.gap != 0)
              check("gap", ncyc - last_chg, e.gap);
`ifdef KEYPAD_STROBE_EN
            check("strobe_at_commit", 32'(key_strobe), 32'(numbers != 0));
`else
            check("strobe_at_commit", 32'(key_strobe), 0);
`endif
          end
          last_num = numbers;
          last_chg = ncyc;
        end
      end
    end
  end

  initial begin : stim
    rst     = 1'b0;
    pressed = '0;
    glitch  = '0;
    #1;
    check("rst_row", 32'(row), 32'h0000000E);
    check("rst_numbers", 32'(numbers), 0);
    check("rst_key_code", 32'(key_code), 0);
    check("rst_strobe", 32'(key_strobe), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // idle row rotation
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("row_cycle", 32'(row), 32'(~(4'b0001 << ((ncyc / 4) % 4)) & 4'hF));
    end
    wait_scans(1);
    check("idle_numbers", 32'(numbers), 0);

    // key 5 press and release
    pressed = 16'h0020;
    push(16'h0020, 4'd5, 0);
    wait_scans(5);
    check("drain_5_press", sb.size(), 0);
    pressed = '0;
    push(16'h0000, 4'd0, 0);
    wait_scans(3);
    check("drain_5_release", sb.size(), 0);

    // key # with single-cycle glitches away from sample points
    pressed = 16'h4000;
    push(16'h8000, 4'd15, 0);
    for (int i = 0; i < 64; i++) begin
      glitch = ((ncyc % 4) == 0) ? 4'hF : 4'h0;
      @(negedge clk);
    end
    glitch = '0;
    wait_scans(1);
    check("drain_hash", sb.size(), 0);
    pressed = '0;
    push(16'h0000, 4'd0, 0);
    wait_scans(3);
    check("drain_hash_release", sb.size(), 0);

    // keys 1 and 2 together are rejected
    pressed = 16'h0003;
    wait_scans(5);
    check("multi_numbers", 32'(numbers), 0);
    check("drain_multi", sb.size(), 0);
    pressed = '0;
    wait_scans(3);

    // C rolled directly onto 7
    pressed = 16'h0800;
    push(16'h1000, 4'd12, 0);
    wait_scans(4);
    check("drain_c", sb.size(), 0);
    pressed = 16'h0100;
    push(16'h0000, 4'd0, 0);
    push(16'h0080, 4'd7, 16);
    wait_scans(5);
    check("drain_c_to_7", sb.size(), 0);
    pressed = '0;
    push(16'h0000, 4'd0, 0);
    wait_scans(3);
    check("drain_7_release", sb.size(), 0);

    // key 0 committed, then reset mid-ROW2
    pressed = 16'h2000;
    push(16'h0001, 4'd0, 0);
    wait_scans(4);
    check("drain_0", sb.size(), 0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      if ((ncyc % 16) == 9) break;
    end
    #2 rst = 1'b0;
    #1;
    check("midrst_row", 32'(row), 32'h0000000E);
    check("midrst_numbers", 32'(numbers), 0);
    check("midrst_key_code", 32'(key_code), 0);
    push(16'h0001, 4'd0, 32);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    wait_scans(3);
    check("drain_0_recommit", sb.size(), 0);
    pressed = '0;
    push(16'h0000, 4'd0, 0);
    wait_scans(3);
    check("drain_0_release", sb.size(), 0);

`ifdef KEYPAD_STROBE_EN
    check("strobe_total", n_strobe, 6);
`else
    check("strobe_total", n_strobe, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
